// File: rtl/cache_l2_nway.sv
// N-way set-associative write-back / write-allocate L2 with true-LRU replacement.
// Tag, valid, dirty and age state live in flops; line data lives in an unreset flop array.
module cache_l2_nway #(
  parameter int unsigned WAYS      = 4,
  parameter int unsigned SETS      = 16,
  parameter int unsigned LINE_BITS = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          mem_addr_l2,
  input  logic                 mem_read_l2,
  input  logic                 mem_write_l2,
  input  logic [LINE_BITS-1:0] mem_wdata_l2,
  output logic                 mem_resp_l2,
  output logic [LINE_BITS-1:0] mem_rdata_l2,
  input  logic [LINE_BITS-1:0] pmem_rdata,
  input  logic                 pmem_resp,
  output logic [31:0]          pmem_address,
  output logic [LINE_BITS-1:0] pmem_wdata,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count
);
  localparam int unsigned OFFW = $clog2(LINE_BITS / 8);
  localparam int unsigned IDXW = $clog2(SETS);
  localparam int unsigned TAGW = 32 - OFFW - IDXW;
  localparam int unsigned AGEW = $clog2(WAYS);

  typedef enum logic [1:0] {IDLE, WB, FILL, RESP} state_e;

  state_e                state_q, state_d;
  logic [TAGW-1:0]       tag_q [SETS][WAYS];
  logic [TAGW-1:0]       tag_d [SETS][WAYS];
  logic [AGEW-1:0]       age_q [SETS][WAYS];
  logic [AGEW-1:0]       age_d [SETS][WAYS];
  logic [LINE_BITS-1:0]  data_q [SETS][WAYS];
  logic [SETS-1:0][WAYS-1:0] valid_q, valid_d, dirty_q, dirty_d;
  logic [AGEW-1:0]       victim_q, victim_d;
  logic                  mem_resp_q, mem_resp_d, pmem_read_q, pmem_read_d;
  logic                  pmem_write_q, pmem_write_d;
  logic [LINE_BITS-1:0]  mem_rdata_q, mem_rdata_d, pmem_wdata_q, pmem_wdata_d;
  logic [31:0]           pmem_address_q, pmem_address_d;
  logic [31:0]           hit_count_q, hit_count_d, miss_count_q, miss_count_d;

  logic [IDXW-1:0]       idx_c;
  logic [TAGW-1:0]       req_tag_c;
  logic                  req_c, is_wr_c, unused_off_c;
  logic                  hit_c, inv_c;
  logic [AGEW-1:0]       hit_way_c, inv_way_c, lru_way_c, vict_c;
  logic                  touch_c, install_c, inst_dirty_c, data_we_c;
  logic [AGEW-1:0]       touch_way_c, inst_way_c, data_way_c;
  logic [LINE_BITS-1:0]  data_wdata_c;

  assign idx_c        = mem_addr_l2[OFFW +: IDXW];
  assign req_tag_c    = mem_addr_l2[31 -: TAGW];
  assign req_c        = mem_read_l2 | mem_write_l2;
  assign is_wr_c      = mem_write_l2;
  assign unused_off_c = ^mem_addr_l2[OFFW-1:0];

  // Tag match, lowest invalid way and oldest way of the addressed set.
  always_comb begin
    hit_c     = 1'b0;
    hit_way_c = '0;
    inv_c     = 1'b0;
    inv_way_c = '0;
    lru_way_c = '0;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (valid_q[idx_c][AGEW'(w)] && (tag_q[idx_c][AGEW'(w)] == req_tag_c)) begin
        hit_c     = 1'b1;
        hit_way_c = AGEW'(w);
      end
      if (!valid_q[idx_c][AGEW'(w)]) begin
        inv_c     = 1'b1;
        inv_way_c = AGEW'(w);
      end
      if (age_q[idx_c][AGEW'(w)] == AGEW'(WAYS - 1)) lru_way_c = AGEW'(w);
    end
  end

  assign vict_c = inv_c ? inv_way_c : lru_way_c;

  // Next state, metadata updates and registered outputs.
  always_comb begin
    state_d        = state_q;
    tag_d          = tag_q;
    age_d          = age_q;
    valid_d        = valid_q;
    dirty_d        = dirty_q;
    victim_d       = victim_q;
    mem_resp_d     = 1'b0;
    mem_rdata_d    = mem_rdata_q;
    pmem_read_d    = 1'b0;
    pmem_write_d   = 1'b0;
    pmem_address_d = '0;
    pmem_wdata_d   = '0;
    hit_count_d    = hit_count_q;
    miss_count_d   = miss_count_q;
    touch_c        = 1'b0;
    touch_way_c    = '0;
    install_c      = 1'b0;
    inst_dirty_c   = 1'b0;
    inst_way_c     = '0;
    data_we_c      = 1'b0;
    data_way_c     = '0;
    data_wdata_c   = mem_wdata_l2;
    unique case (state_q)
      IDLE: begin
        if (req_c && hit_c) begin
          if (hit_count_q != '1) hit_count_d = hit_count_q + 32'd1;
          touch_c     = 1'b1;
          touch_way_c = hit_way_c;
          if (is_wr_c) begin
            data_we_c                  = 1'b1;
            data_way_c                 = hit_way_c;
            dirty_d[idx_c][hit_way_c]  = 1'b1;
          end else begin
            mem_rdata_d = data_q[idx_c][hit_way_c];
          end
          state_d    = RESP;
          mem_resp_d = 1'b1;
        end else if (req_c) begin
          if (miss_count_q != '1) miss_count_d = miss_count_q + 32'd1;
          victim_d = vict_c;
          if (valid_q[idx_c][vict_c] && dirty_q[idx_c][vict_c]) begin
            state_d        = WB;
            pmem_write_d   = 1'b1;
            pmem_address_d = {tag_q[idx_c][vict_c], idx_c, {OFFW{1'b0}}};
            pmem_wdata_d   = data_q[idx_c][vict_c];
          end else if (is_wr_c) begin
            install_c    = 1'b1;
            inst_dirty_c = 1'b1;
            inst_way_c   = vict_c;
          end else begin
            state_d        = FILL;
            pmem_read_d    = 1'b1;
            pmem_address_d = {req_tag_c, idx_c, {OFFW{1'b0}}};
          end
        end
      end
      WB: begin
        pmem_write_d   = 1'b1;
        pmem_address_d = pmem_address_q;
        pmem_wdata_d   = pmem_wdata_q;
        if (pmem_resp) begin
          dirty_d[idx_c][victim_q] = 1'b0;
          pmem_write_d             = 1'b0;
          pmem_address_d           = '0;
          pmem_wdata_d             = '0;
          if (is_wr_c) begin
            install_c    = 1'b1;
            inst_dirty_c = 1'b1;
            inst_way_c   = victim_q;
          end else begin
            state_d        = FILL;
            pmem_read_d    = 1'b1;
            pmem_address_d = {req_tag_c, idx_c, {OFFW{1'b0}}};
          end
        end
      end
      FILL: begin
        pmem_read_d    = 1'b1;
        pmem_address_d = pmem_address_q;
        if (pmem_resp) begin
          pmem_read_d    = 1'b0;
          pmem_address_d = '0;
          install_c      = 1'b1;
          inst_way_c     = victim_q;
          mem_rdata_d    = pmem_rdata;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Write-installs carry requester data dirty; fills carry memory data clean.
    if (install_c) begin
      tag_d[idx_c][inst_way_c]   = req_tag_c;
      valid_d[idx_c][inst_way_c] = 1'b1;
      dirty_d[idx_c][inst_way_c] = inst_dirty_c;
      data_we_c                  = 1'b1;
      data_way_c                 = inst_way_c;
      data_wdata_c               = inst_dirty_c ? mem_wdata_l2 : pmem_rdata;
      touch_c                    = 1'b1;
      touch_way_c                = inst_way_c;
      state_d                    = RESP;
      mem_resp_d                 = 1'b1;
    end

    if (touch_c) begin
      for (int w = 0; w < int'(WAYS); w++) begin
        if (age_q[idx_c][AGEW'(w)] < age_q[idx_c][touch_way_c])
          age_d[idx_c][AGEW'(w)] = age_q[idx_c][AGEW'(w)] + 1'b1;
      end
      age_d[idx_c][touch_way_c] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      valid_q        <= '0;
      dirty_q        <= '0;
      victim_q       <= '0;
      mem_resp_q     <= 1'b0;
      mem_rdata_q    <= '0;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
      hit_count_q    <= '0;
      miss_count_q   <= '0;
      for (int s = 0; s < int'(SETS); s++) begin
        for (int w = 0; w < int'(WAYS); w++) begin
          tag_q[s][w] <= '0;
          age_q[s][w] <= AGEW'(w);
        end
      end
    end else begin
      state_q        <= state_d;
      tag_q          <= tag_d;
      age_q          <= age_d;
      valid_q        <= valid_d;
      dirty_q        <= dirty_d;
      victim_q       <= victim_d;
      mem_resp_q     <= mem_resp_d;
      mem_rdata_q    <= mem_rdata_d;
      pmem_read_q    <= pmem_read_d;
      pmem_write_q   <= pmem_write_d;
      pmem_address_q <= pmem_address_d;
      pmem_wdata_q   <= pmem_wdata_d;
      hit_count_q    <= hit_count_d;
      miss_count_q   <= miss_count_d;
    end
  end

  // Line data needs no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (data_we_c) data_q[idx_c][data_way_c] <= data_wdata_c;
  end

  assign mem_resp_l2  = mem_resp_q;
  assign mem_rdata_l2 = mem_rdata_q;
  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;
  assign hit_count    = hit_count_q;
  assign miss_count   = miss_count_q;
endmodule

// File: tb/tb_cache_l2_nway.sv
// Bench for cache_l2_nway: recency-list cache model plus memory model, directed scenarios
// followed by randomized traffic with random memory latency.
module tb_cache_l2_nway;
  localparam int unsigned LB = 256;

  logic          clk, rst_n;
  logic [31:0]   mem_addr_l2;
  logic          mem_read_l2, mem_write_l2, mem_resp_l2;
  logic [LB-1:0] mem_wdata_l2, mem_rdata_l2, pmem_rdata, pmem_wdata;
  logic          pmem_resp, pmem_read, pmem_write;
  logic [31:0]   pmem_address, hit_count, miss_count;

  cache_l2_nway #(.WAYS(4), .SETS(16), .LINE_BITS(LB)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_addr_l2(mem_addr_l2), .mem_read_l2(mem_read_l2), .mem_write_l2(mem_write_l2),
    .mem_wdata_l2(mem_wdata_l2), .mem_resp_l2(mem_resp_l2), .mem_rdata_l2(mem_rdata_l2),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit            v;
    bit            d;
    logic [22:0]   tag;
    logic [LB-1:0] data;
  } mline_t;

  mline_t        mdl [16][4];
  int            rec [16][$];          // per-set recency list, front = most recent
  logic [LB-1:0] mem [logic [31:0]];
  int            hcnt, mcnt;
  int            checks, errors;
  bit            run_chk;
  logic [31:0]   last_wb_addr, last_fill_addr;
  logic [LB-1:0] last_wb_data;

  task automatic chk(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [LB-1:0] mem_get(input logic [31:0] a);
    logic [LB-1:0] r;
    if (mem.exists(a)) return mem[a];
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = a ^ (32'h9E37_79B9 * (k + 1));
    return r;
  endfunction

  function automatic logic [LB-1:0] rnd_line();
    logic [LB-1:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 16; s++) begin
      rec[s].delete();
      for (int w = 0; w < 4; w++) begin
        mdl[s][w].v    = 1'b0;
        mdl[s][w].d    = 1'b0;
        mdl[s][w].tag  = '0;
        mdl[s][w].data = '0;
        rec[s].push_back(w);
      end
    end
    hcnt = 0;
    mcnt = 0;
  endtask

  task automatic touch(input int s, input int w);
    int pos = 0;
    for (int i = 0; i < rec[s].size(); i++) if (rec[s][i] == w) pos = i;
    rec[s].delete(pos);
    rec[s].push_front(w);
  endtask

  // One request: predict from the model, drive it, play memory, then compare.
  task automatic do_req(input logic [31:0] addr, input bit rd, input bit wr,
                        input logic [LB-1:0] wd, input int lat, input bit noise);
    int            s, hw, v, n, cnt, fill_n;
    logic [22:0]   t;
    bit            hit, isw, exp_wb, exp_fill, done, wb_seen, fill_seen;
    logic [31:0]   exp_wb_addr, exp_fill_addr;
    logic [LB-1:0] exp_wb_data, exp_rd;
    s = int'(addr[8:5]);
    t = addr[31:9];
    isw = wr;
    hw = -1; v = -1;
    exp_wb = 1'b0; exp_fill = 1'b0;
    exp_wb_addr = '0; exp_fill_addr = '0; exp_wb_data = '0; exp_rd = '0;
    for (int w = 0; w < 4; w++) if (mdl[s][w].v && mdl[s][w].tag == t) hw = w;
    hit = (hw >= 0);
    if (hit) begin
      hcnt++;
      if (isw) begin
        mdl[s][hw].data = wd;
        mdl[s][hw].d    = 1'b1;
      end else begin
        exp_rd = mdl[s][hw].data;
      end
      touch(s, hw);
    end else begin
      mcnt++;
      for (int w = 3; w >= 0; w--) if (!mdl[s][w].v) v = w;
      if (v < 0) v = rec[s][$];
      if (mdl[s][v].v && mdl[s][v].d) begin
        exp_wb      = 1'b1;
        exp_wb_addr = {mdl[s][v].tag, 4'(s), 5'b0};
        exp_wb_data = mdl[s][v].data;
        mem[exp_wb_addr] = exp_wb_data;
      end
      if (isw) begin
        mdl[s][v].data = wd;
        mdl[s][v].d    = 1'b1;
      end else begin
        exp_fill      = 1'b1;
        exp_fill_addr = {addr[31:5], 5'b0};
        exp_rd        = mem_get(exp_fill_addr);
        mdl[s][v].data = exp_rd;
        mdl[s][v].d    = 1'b0;
      end
      mdl[s][v].v   = 1'b1;
      mdl[s][v].tag = t;
      touch(s, v);
    end

    mem_addr_l2 = addr; mem_read_l2 = rd; mem_write_l2 = wr; mem_wdata_l2 = wd;
    n = 0; cnt = 0; fill_n = 0; done = 1'b0; wb_seen = 1'b0; fill_seen = 1'b0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
      pmem_resp  = 1'b0;
      pmem_rdata = rnd_line();
      if (mem_resp_l2) begin
        done = 1'b1;
      end else if (pmem_write) begin
        if (!wb_seen) begin
          wb_seen = 1'b1; cnt = 0;
          last_wb_addr = pmem_address; last_wb_data = pmem_wdata;
          chk("wb_addr", pmem_address, exp_wb_addr);
          chk("wb_data", pmem_wdata, exp_wb_data);
        end
        if (cnt == lat) pmem_resp = 1'b1;
        cnt++;
      end else if (pmem_read) begin
        if (!fill_seen) begin
          fill_seen = 1'b1; cnt = 0; fill_n = n;
          last_fill_addr = pmem_address;
          chk("fill_addr", pmem_address, exp_fill_addr);
        end
        if (cnt == lat) begin
          pmem_resp  = 1'b1;
          pmem_rdata = mem_get(pmem_address);
        end
        cnt++;
      end
    end
    chk("resp_seen", done, 1);
    chk("wb_done", wb_seen, exp_wb);
    chk("fill_done", fill_seen, exp_fill);
    if (hit || (isw && !exp_wb)) chk("resp_latency", n, 1);
    if (!hit && !exp_wb && !isw) chk("fill_start", fill_n, 1);
    if (!isw) chk("rdata", mem_rdata_l2, exp_rd);
    chk("hit_count", hit_count, hcnt);
    chk("miss_count", miss_count, mcnt);
    mem_read_l2 = 1'b0; mem_write_l2 = 1'b0; mem_wdata_l2 = rnd_line();
    @(posedge clk); #1;
    chk("resp_one_cycle", mem_resp_l2, 0);
    if (noise) begin
      pmem_resp = 1'b1;
      @(posedge clk); #1;
      pmem_resp = 1'b0;
    end
  endtask

  // Every-cycle protocol checks on the memory side.
  always @(negedge clk) begin
    if (run_chk && rst_n) begin
      chk("pmem_exclusive", pmem_read & pmem_write, 0);
      if (!pmem_read && !pmem_write) begin
        chk("pmem_addr_idle", pmem_address, 0);
        chk("pmem_wdata_idle", pmem_wdata, 0);
      end
    end
  end

  initial begin
    logic [LB-1:0] d_line, w_line, e_line;
    int            k;
    checks = 0; errors = 0; run_chk = 1'b0;
    rst_n = 1'b0;
    mem_addr_l2 = '0; mem_read_l2 = 1'b0; mem_write_l2 = 1'b0; mem_wdata_l2 = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;
    last_wb_addr = '0; last_fill_addr = '0; last_wb_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_resp", mem_resp_l2, 0);
    chk("rst_pmem_read", pmem_read, 0);
    chk("rst_pmem_write", pmem_write, 0);
    chk("rst_pmem_addr", pmem_address, 0);
    chk("rst_rdata", mem_rdata_l2, 0);
    chk("rst_hits", hit_count, 0);
    chk("rst_misses", miss_count, 0);
    rst_n = 1'b1;
    run_chk = 1'b1;
    @(posedge clk); #1;

    // Cold read miss then hit.
    do_req(32'h0000_1000, 1'b1, 1'b0, rnd_line(), 2, 1'b0);
    chk("t1_fill_addr", last_fill_addr, 32'h0000_1000);
    do_req(32'h0000_1000, 1'b1, 1'b0, rnd_line(), 0, 1'b0);
    chk("t1_hits", hit_count, 1);
    chk("t1_misses", miss_count, 1);

    // LRU: 0x200 becomes the oldest and is evicted by 0x800.
    do_req(32'h000, 1'b1, 1'b0, rnd_line(), 1, 1'b0);
    do_req(32'h200, 1'b1, 1'b0, rnd_line(), 1, 1'b0);
    do_req(32'h400, 1'b1, 1'b0, rnd_line(), 1, 1'b0);
    do_req(32'h600, 1'b1, 1'b0, rnd_line(), 1, 1'b0);
    do_req(32'h000, 1'b1, 1'b0, rnd_line(), 1, 1'b0);
    do_req(32'h800, 1'b1, 1'b0, rnd_line(), 1, 1'b0);
    do_req(32'h200, 1'b1, 1'b0, rnd_line(), 1, 1'b0);
    do_req(32'h000, 1'b1, 1'b0, rnd_line(), 1, 1'b0);
    chk("t2_hits", hit_count, 3);
    chk("t2_misses", miss_count, 7);

    // Dirty line written back on eviction, then the new tag is fetched.
    d_line = {8{32'hD00D_F00D}};
    do_req(32'h000, 1'b0, 1'b1, d_line, 1, 1'b0);
    do_req(32'hA00, 1'b1, 1'b0, rnd_line(), 1, 1'b0);
    do_req(32'hC00, 1'b1, 1'b0, rnd_line(), 1, 1'b0);
    do_req(32'hE00, 1'b1, 1'b0, rnd_line(), 1, 1'b0);
    do_req(32'h1000, 1'b1, 1'b0, rnd_line(), 1, 1'b0);
    chk("t3_wb_addr", last_wb_addr, 32'h0);
    chk("t3_wb_data", last_wb_data, d_line);
    chk("t3_fill_addr", last_fill_addr, 32'h0000_1000);
    chk("t3_hits", hit_count, 4);
    chk("t3_misses", miss_count, 11);

    // Write miss with clean victim installs without a fill.
    w_line = {8{32'h1E00_CAFE}};
    do_req(32'h1E00, 1'b0, 1'b1, w_line, 1, 1'b0);
    do_req(32'h1E00, 1'b1, 1'b0, rnd_line(), 1, 1'b0);
    chk("t4_rdata", mem_rdata_l2, w_line);
    chk("t4_hits", hit_count, 5);

    // Reset in the middle of a fill.
    mem_addr_l2 = 32'h2000; mem_read_l2 = 1'b1;
    k = 0;
    while (!pmem_read && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    chk("t5_fill_started", pmem_read, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_pmem_read", pmem_read, 0);
    chk("t5_pmem_addr", pmem_address, 0);
    chk("t5_hits", hit_count, 0);
    chk("t5_misses", miss_count, 0);
    mem_read_l2 = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_req(32'h1E00, 1'b1, 1'b0, rnd_line(), 2, 1'b0);
    chk("t5_miss_after_rst", miss_count, 1);
    chk("t5_no_hits", hit_count, 0);

    // Read and write together act as a write; the dirty line is written back later.
    e_line = {8{32'hB07B_0001}};
    do_req(32'h000, 1'b1, 1'b1, e_line, 0, 1'b0);
    do_req(32'h200, 1'b1, 1'b0, rnd_line(), 0, 1'b0);
    do_req(32'h400, 1'b1, 1'b0, rnd_line(), 0, 1'b0);
    do_req(32'h600, 1'b1, 1'b0, rnd_line(), 0, 1'b0);
    do_req(32'h800, 1'b1, 1'b0, rnd_line(), 0, 1'b0);
    chk("t6_wb_addr", last_wb_addr, 32'h0);
    chk("t6_wb_data", last_wb_data, e_line);

    // Random traffic over a few sets and tags.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      int          op;
      a  = (32'($urandom_range(0, 5)) << 9) | (32'($urandom_range(0, 3)) << 5)
         | 32'($urandom_range(0, 31));
      op = $urandom_range(0, 2);
      do_req(a, op != 1, op != 0, rnd_line(), $urandom_range(0, 4), $urandom_range(0, 1) == 1);
    end

    run_chk = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule

// File: doc/cache_l2_nway.md
# cache_l2_nway

Parametrised N-way set-associative, write-back, write-allocate L2 cache that sits between the L1 caches' arbiter (line-granular requests) and physical memory. It generalises the direct-mapped L2 to configurable ways and sets, with true-LRU replacement, write-miss install without fetch, asynchronous reset of all tag state and hit/miss performance counters. Control is a single FSM, and tag, valid, dirty and LRU state are held in flops.

## Interface
- WAYS, 4, associativity; power of two, 2..8
- SETS, 16, sets; power of two, 2..256
- LINE_BITS, 256, line width; offset bits = log2(LINE_BITS/8) = 5
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- mem_addr_l2  in  32  request byte address; offset bits ignored
- mem_read_l2  in  1  read request, held until mem_resp_l2
- mem_write_l2  in  1  write request (full line), held until mem_resp_l2
- mem_wdata_l2  in  LINE_BITS  write line
- mem_resp_l2  out  1  one-cycle completion pulse
- mem_rdata_l2  out  LINE_BITS  read line, valid while mem_resp_l2=1
- pmem_rdata  in  LINE_BITS  memory read line
- pmem_resp  in  1  memory completion pulse
- pmem_address  out  32  line-aligned memory address
- pmem_wdata  out  LINE_BITS  writeback line
- pmem_read, pmem_write  out  1 each  memory requests, held until pmem_resp
- hit_count, miss_count  out  32 each  saturating request counters

## Operation
- Address split: offset [4:0], index [4+log2(SETS):5], tag is the remaining upper bits.
- When both mem_read_l2 and mem_write_l2 are asserted, the request is treated as a write.
- FSM states: IDLE, WB, FILL, RESP.
- IDLE, no request: stay in IDLE.
- IDLE, hit: read registers the line into mem_rdata_l2; write stores mem_wdata_l2 and sets dirty. Both update LRU, increment hit_count and go to RESP.
- IDLE, miss: increment miss_count and latch the victim way.
  - Dirty victim: go to WB.
  - Clean victim, read: go to FILL.
  - Clean victim, write: install mem_wdata_l2 (tag, valid=1, dirty=1), update LRU, go to RESP. No fill.
- WB: pmem_write=1, pmem_address={victim tag, index, 5'b0}, pmem_wdata=victim line. On pmem_resp, clear the victim's dirty bit. Read goes to FILL; write installs as above and goes to RESP.
- FILL: pmem_read=1, pmem_address={req tag, index, 5'b0}. On pmem_resp, install the line (valid=1, dirty=0), register mem_rdata_l2=pmem_rdata, update LRU, go to RESP.
- RESP: mem_resp_l2=1 for exactly one cycle, then IDLE.
- Victim choice: lowest-index invalid way if one exists; otherwise the way with age WAYS-1.
- LRU: each way holds a log2(WAYS)-bit age per set. On access to way w, every way with age < age(w) increments, then age(w)=0. Reset ages: way i = i.
- pmem_address and pmem_wdata are 0 whenever neither pmem_read nor pmem_write is asserted.
- Counters saturate at 0xFFFF_FFFF. Each request is counted once, in IDLE.

## Timing
- Reset (asynchronous, immediate):
  - State returns to IDLE.
  - All valid and dirty bits clear; ages reset to i.
  - mem_resp_l2, pmem_read and pmem_write drop to 0.
  - mem_rdata_l2, pmem_address, pmem_wdata and both counters go to 0.
  - Dirty data is discarded, including reset asserted mid-WB or mid-FILL.
- Hit latency: request seen in IDLE at cycle 0, mem_resp_l2 at cycle 1.
- Read miss with clean victim: FILL from cycle 1; mem_resp_l2 one cycle after pmem_resp.
- Dirty miss: WB, then FILL (read) or install (write). pmem_write and pmem_read are never asserted together.
- The requester must drop its request in the cycle after mem_resp_l2. IDLE samples a new request no earlier than the cycle after RESP.
- pmem_resp outside WB or FILL is ignored.
- A hit in IDLE never touches pmem.

## Test plan
All scenarios use WAYS=4, SETS=16; index=[8:5], so same-set stride is 0x200.
- After reset, read 0x0000_1000 with pmem_resp 3 cycles later carrying line A -> pmem_read with address 0x0000_1000, then mem_resp_l2 with A. Re-read -> resp at cycle 1, pmem idle; hit_count=1, miss_count=1.
- Read 0x000, 0x200, 0x400, 0x600, then 0x000 again, then 0x800 -> 0x200 is evicted. A following read of 0x200 misses; 0x000 still hits.
- Write line D to 0x000 (hit), then force its eviction -> pmem_write at 0x000 with D, pmem_resp, then pmem_read for the new tag.
- Write miss to 0x1E00 with a clean victim -> no pmem_read, resp within 2 cycles. Read 0x1E00 -> hit returning the written data.
- Assert rst_n=0 mid-FILL -> pmem_read low in the same cycle, counters 0. A previously cached line now misses.
- mem_read_l2 and mem_write_l2 both high to 0x000 -> line written, dirty=1, behaves as a write; a later eviction writes it back.
